comp_seq_ctrl: RTL and testbench



---
 rtl/comp_seq_if.sv | 27 ++
 rtl/comp_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_comp_seq_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp_seq_if.sv
// Operand/result handshake bundle for comp_seq_ctrl; the master drives operands, the slave is the controller.
// Signal names are taken from the controller's point of view (i_ = into the controller).
interface comp_seq_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_data_a;
   logic [WIDTH-1:0] i_data_b;
   logic             o_valid;
   logic             i_ready;
   logic             o_less;
   logic             o_equal;
   logic             o_greater;
   logic             o_swap;
   logic             o_busy;

   modport master (
      output i_valid, i_data_a, i_data_b, i_ready,
      input  o_ready, o_valid, o_less, o_equal, o_greater, o_swap, o_busy
   );

   modport slave (
      input  i_valid, i_data_a, i_data_b, i_ready,
      output o_ready, o_valid, o_less, o_equal, o_greater, o_swap, o_busy
   );
endinterface

// File: rtl/comp_seq_ctrl.sv
// Sequential MSB-first magnitude comparator, two bits per cycle, for the ADD_SUB alignment stage.
// Optional build macro COMP_SEQ_EARLY_EXIT_EN: finish the scan on the first unequal bit pair.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for operands; accept latches A/B and clears the flags
// ST_SCAN | compare top pair of A/B shift registers, shift by 2 per cycle
// ST_DONE | result valid; flags held until the consumer takes it
module comp_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input logic       i_clk,
   input logic       i_rst,
   comp_seq_if.slave bus
);
   localparam int NPAIR = WIDTH / 2;
   localparam int IDXW  = (NPAIR > 1) ? $clog2(NPAIR) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDXW-1:0]  r_idx;
   logic             r_less;
   logic             r_equal;
   logic             r_greater;
   logic             r_busy;

   logic [1:0]       w_pair_a;
   logic [1:0]       w_pair_b;
   logic             w_pair_lt;
   logic             w_pair_gt;
   logic             w_decided;
   logic             w_last;
   logic             w_exit;
   logic             w_accept;
   logic             w_scan;

   assign w_pair_a  = r_a[WIDTH-1 -: 2];
   assign w_pair_b  = r_b[WIDTH-1 -: 2];
   assign w_pair_lt = (w_pair_a < w_pair_b);
   assign w_pair_gt = (w_pair_a > w_pair_b);
   assign w_decided = r_less | r_greater;
   assign w_last    = (r_idx == '0);
   assign w_accept  = bus.i_valid && (r_state == ST_IDLE);
   assign w_scan    = (r_state == ST_SCAN);

`ifdef COMP_SEQ_EARLY_EXIT_EN
   assign w_exit = w_last | w_pair_lt | w_pair_gt;
`else
   assign w_exit = w_last;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.i_valid) w_state_nxt = ST_SCAN;
         ST_SCAN: if (w_exit)      w_state_nxt = ST_DONE;
         ST_DONE: if (bus.i_ready) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   // The first unequal pair owns the result; later pairs only matter while nothing is decided.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_less    <= 1'b0;
         r_equal   <= 1'b0;
         r_greater <= 1'b0;
      end else if (w_accept) begin
         r_a       <= bus.i_data_a;
         r_b       <= bus.i_data_b;
         r_idx     <= IDXW'(NPAIR - 1);
         r_less    <= 1'b0;
         r_equal   <= 1'b0;
         r_greater <= 1'b0;
      end else if (w_scan) begin
         r_a <= r_a << 2;
         r_b <= r_b << 2;
         if (!w_last) begin
            r_idx <= r_idx - IDXW'(1);
         end
         if (!w_decided) begin
            r_less    <= w_pair_lt;
            r_greater <= w_pair_gt;
            r_equal   <= w_last & ~w_pair_lt & ~w_pair_gt;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE);
      end
   end

   assign bus.o_ready   = (r_state == ST_IDLE);
   assign bus.o_valid   = (r_state == ST_DONE);
   assign bus.o_less    = r_less;
   assign bus.o_equal   = r_equal;
   assign bus.o_greater = r_greater;
   assign bus.o_swap    = r_less;
   assign bus.o_busy    = r_busy;
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed and randomized bench for comp_seq_ctrl: an 8-bit instance for the directed cases and a 32-bit instance for streaming.
// Latency expectations follow COMP_SEQ_EARLY_EXIT_EN when it is defined for the build.
module tb_comp_seq_ctrl;
`ifdef COMP_SEQ_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int EXP_FULL8 = 5;
   localparam int EXP_MSB8  = EARLY ? 2 : 5;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   comp_seq_if #(.WIDTH(8))  if8 ();
   comp_seq_if #(.WIDTH(32)) if32 ();

   comp_seq_ctrl #(.WIDTH(8)) u_dut8 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if8.slave)
   );

   comp_seq_ctrl #(.WIDTH(32)) u_dut32 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (if32.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pairs evaluated: all of them, or up to and including the first unequal pair from the top.
   function automatic int ref_k(input logic [31:0] a, input logic [31:0] b, input int npair);
      int  k;
      bit  found;
      k     = npair;
      found = 1'b0;
      if (EARLY) begin
         for (int p = npair - 1; p >= 0; p--) begin
            if (!found && (((a >> (2 * p)) & 32'd3) != ((b >> (2 * p)) & 32'd3))) begin
               k     = npair - p;
               found = 1'b1;
            end
         end
      end
      return k;
   endfunction

   function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
      return {a < b, a == b, a > b, a < b};
   endfunction

   task automatic txn8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input int exp_cyc, input bit bp);
      int         n;
      logic [3:0] exp_f;
      logic [3:0] got_f;
      exp_f = ref_flags({24'd0, a}, {24'd0, b});
      chk({tag, "_ready_in"}, if8.o_ready, 1);
      if8.i_data_a = a;
      if8.i_data_b = b;
      if8.i_valid  = 1'b1;
      if8.i_ready  = 1'b0;
      @(posedge clk); #1;
      if8.i_valid  = bp;
      if8.i_data_a = ~a;
      if8.i_data_b = ~b;
      chk({tag, "_busy_c1"}, {if8.o_busy, if8.o_ready}, 2'b10);
      n = 0;
      while (!if8.o_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, n + 1, exp_cyc);
      got_f = {if8.o_less, if8.o_equal, if8.o_greater, if8.o_swap};
      chk({tag, "_flags"}, got_f, exp_f);
      chk({tag, "_busy_done"}, {if8.o_busy, if8.o_ready}, 2'b10);
      if (bp) begin
         for (int i = 0; i < 3; i++) begin
            if8.i_data_a = 8'($urandom);
            if8.i_data_b = 8'($urandom);
            @(posedge clk); #1;
            got_f = {if8.o_less, if8.o_equal, if8.o_greater, if8.o_swap};
            chk({tag, "_hold_valid"}, {if8.o_valid, if8.o_ready}, 2'b10);
            chk({tag, "_hold_flags"}, got_f, exp_f);
         end
      end
      if8.i_ready = 1'b1;
      @(posedge clk); #1;
      if8.i_ready = 1'b0;
      if8.i_valid = 1'b0;
      got_f = {if8.o_less, if8.o_equal, if8.o_greater, if8.o_swap};
      chk({tag, "_release"}, {if8.o_valid, if8.o_ready, if8.o_busy}, 3'b010);
      chk({tag, "_flags_kept"}, got_f, exp_f);
   endtask

   initial begin
      logic [31:0]     a32;
      logic [31:0]     b32;
      logic [7:0]      ra;
      logic [7:0]      rb;
      logic [31:0]     qa[$];
      logic [31:0]     qb[$];
      int              qacc[$];
      int              cyc;
      int              accepts;
      int              results;
      logic [3:0]      got_f;

      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      if8.i_valid  = 1'b0;
      if8.i_ready  = 1'b0;
      if8.i_data_a = '0;
      if8.i_data_b = '0;
      if32.i_valid  = 1'b0;
      if32.i_ready  = 1'b0;
      if32.i_data_a = '0;
      if32.i_data_b = '0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {if8.o_valid, if8.o_less, if8.o_equal, if8.o_greater,
                            if8.o_swap, if8.o_busy}, 6'b0);
      rst = 1'b0;
      chk("reset_ready8", if8.o_ready, 1);
      chk("reset_ready32", {if32.o_ready, if32.o_valid, if32.o_busy}, 3'b100);

      txn8("equal_a5", 8'hA5, 8'hA5, EXP_FULL8, 1'b0);
      txn8("msb_diff", 8'h40, 8'h80, EXP_MSB8, 1'b0);
      txn8("lsb_diff", 8'h13, 8'h12, EXP_FULL8, 1'b0);
      txn8("zero_ff", 8'h00, 8'hFF, EXP_MSB8, 1'b0);
      txn8("backpressure", 8'h37, 8'h36, EXP_FULL8, 1'b1);

      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom);
         rb = (i % 2 == 0) ? (ra ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom);
         txn8("rand8", ra, rb, ref_k({24'd0, ra}, {24'd0, rb}, 4) + 1, 1'b0);
      end

      // Reset during the second cycle of a compare.
      if8.i_data_a = 8'h40;
      if8.i_data_b = 8'h80;
      if8.i_valid  = 1'b1;
      @(posedge clk); #1;
      if8.i_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_async", {if8.o_valid, if8.o_less, if8.o_equal, if8.o_greater,
                            if8.o_swap, if8.o_busy}, 6'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_ready", {if8.o_ready, if8.o_busy}, 2'b10);
      txn8("after_rst", 8'h01, 8'h02, ref_k(32'h01, 32'h02, 4) + 1, 1'b0);

      // Streaming at 32 bits with both handshakes held high.
      accepts = 0;
      results = 0;
      cyc     = 0;
      if32.i_ready = 1'b1;
      a32 = $urandom;
      b32 = $urandom;
      if32.i_data_a = a32;
      if32.i_data_b = b32;
      if32.i_valid  = 1'b1;
      while (results < 24 && cyc < 2000) begin
         if (if32.o_valid) begin
            if (qa.size() == 0) begin
               chk("b2b_spurious_valid", 1, 0);
            end else begin
               a32   = qa.pop_front();
               b32   = qb.pop_front();
               got_f = {if32.o_less, if32.o_equal, if32.o_greater, if32.o_swap};
               chk("b2b_flags", got_f, ref_flags(a32, b32));
               chk("b2b_latency", cyc - qacc.pop_front() + 1, ref_k(a32, b32, 16) + 1);
               results++;
            end
         end
         if (if32.o_ready && if32.i_valid) begin
            qa.push_back(if32.i_data_a);
            qb.push_back(if32.i_data_b);
            qacc.push_back(cyc + 1);
            accepts++;
         end
         @(posedge clk); #1;
         cyc++;
         if (accepts >= 24) begin
            if32.i_valid = 1'b0;
         end else begin
            a32 = $urandom;
            case ($urandom_range(0, 3))
               0: b32 = $urandom;
               1: b32 = a32;
               2: b32 = a32 ^ (32'd1 << $urandom_range(0, 31));
               default: b32 = {a32[31:16], 16'($urandom)};
            endcase
            if32.i_data_a = a32;
            if32.i_data_b = b32;
         end
      end
      repeat (20) begin
         @(posedge clk); #1;
         if (if32.o_valid) results++;
      end
      chk("b2b_result_count", results, 24);
      chk("b2b_accept_count", accepts, 24);
      chk("b2b_idle_end", {if32.o_ready, if32.o_busy}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
